volley_ctrl: RTL and testbench

Rally controller for the 3D pong datapath, directly upstream of the projectile integrator. Every frame it reads the ball position produced by the integrator and the two paddle positions. It then drives the integrator's per-axis velocities and its pause/recenter input. It owns wall reflection, paddle hit and miss detection, rally speed-up, the serve/miss/game-over sequencing and both scores.

---
 rtl/volley_ctrl.sv | 154 +++++++++++++++
 tb/tb_volley_ctrl.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/volley_ctrl.sv
// volley_ctrl: rally FSM for 3D pong; reflects walls, detects paddle hits/misses, scores and sequences serves.
module volley_ctrl #(
  parameter logic [9:0] X_MIN       = 10'd64,
  parameter logic [9:0] X_MAX       = 10'd576,
  parameter logic [9:0] Y_MIN       = 10'd48,
  parameter logic [9:0] Y_MAX       = 10'd432,
  parameter logic [9:0] Z_NEAR      = 10'd8,
  parameter logic [9:0] Z_FAR       = 10'd120,
  parameter logic [9:0] PAD_HW      = 10'd40,
  parameter logic [9:0] PAD_HH      = 10'd30,
  parameter logic [9:0] V0_XY       = 10'd1,
  parameter logic [9:0] V0_Z        = 10'd2,
  parameter logic [9:0] VZ_MAX      = 10'd6,
  parameter logic [9:0] VXY_MAX     = 10'd4,
  parameter logic [3:0] HITS_PER_UP = 4'd4,
  parameter logic [7:0] MISS_HOLD   = 8'd60,
  parameter logic [3:0] WIN_SCORE   = 4'd7
) (
  input  logic       frame_clk,
  input  logic       level_rst,
  input  logic       serve,
  input  logic [9:0] pos_x,
  input  logic [9:0] pos_y,
  input  logic [9:0] pos_z,
  input  logic [9:0] ply_x,
  input  logic [9:0] ply_y,
  input  logic [9:0] cpu_x,
  input  logic [9:0] cpu_y,
  output logic [9:0] vel_x,
  output logic [9:0] vel_y,
  output logic [9:0] vel_z,
  output logic       pause,
  output logic [3:0] player_score,
  output logic [3:0] cpu_score,
  output logic       hit_pulse,
  output logic       miss_pulse,
  output logic       game_over
);
  typedef enum logic [1:0] {SERVE, PLAY, MISS, OVER} state_t;
  state_t state, state_n;
  logic serve_q, serve_dir, serve_dir_n, hit_n, miss_n;
  logic [9:0] vz_mag, vz_mag_n, vel_x_n, vel_y_n, vel_z_n;
  logic [3:0] hit_cnt, hit_cnt_n, player_n, cpu_n, cnt_inc;
  logic [7:0] hold, hold_n;
  logic x_flip, y_flip, near, far, on_pad, up, over, under;
  logic [9:0] pad_x, pad_y, vx1, vy1, adx, ady, mag_up;
  logic signed [10:0] dx, dy, eng;
  logic signed [11:0] vx_e;
  always_ff @(posedge frame_clk or posedge level_rst)
    if (level_rst) begin
      state        <= SERVE;
      serve_q      <= 1'b1;
      serve_dir    <= 1'b0;
      vz_mag       <= V0_Z;
      hit_cnt      <= '0;
      hold         <= '0;
      vel_x        <= '0;
      vel_y        <= '0;
      vel_z        <= '0;
      player_score <= '0;
      cpu_score    <= '0;
      hit_pulse    <= 1'b0;
      miss_pulse   <= 1'b0;
      pause        <= 1'b1;
      game_over    <= 1'b0;
    end else begin
      state        <= state_n;
      serve_q      <= serve;
      serve_dir    <= serve_dir_n;
      vz_mag       <= vz_mag_n;
      hit_cnt      <= hit_cnt_n;
      hold         <= hold_n;
      vel_x        <= vel_x_n;
      vel_y        <= vel_y_n;
      vel_z        <= vel_z_n;
      player_score <= player_n;
      cpu_score    <= cpu_n;
      hit_pulse    <= hit_n;
      miss_pulse   <= miss_n;
      pause        <= state_n != PLAY;
      game_over    <= state_n == OVER;
    end
  always_comb begin
    x_flip  = (pos_x >= X_MAX && !vel_x[9] && vel_x != '0) || (pos_x <= X_MIN && vel_x[9]);
    y_flip  = (pos_y >= Y_MAX && !vel_y[9] && vel_y != '0) || (pos_y <= Y_MIN && vel_y[9]);
    vx1     = x_flip ? -vel_x : vel_x;
    vy1     = y_flip ? -vel_y : vel_y;
    near    = pos_z <= Z_NEAR && vel_z[9];
    far     = pos_z >= Z_FAR && !vel_z[9] && vel_z != '0;
    pad_x   = near ? ply_x : cpu_x;
    pad_y   = near ? ply_y : cpu_y;
    dx      = {1'b0, pos_x} - {1'b0, pad_x};
    dy      = {1'b0, pos_y} - {1'b0, pad_y};
    adx     = dx[10] ? 10'(-dx) : dx[9:0];
    ady     = dy[10] ? 10'(-dy) : dy[9:0];
    on_pad  = adx <= PAD_HW && ady <= PAD_HH;
    eng     = dx >>> 4;
    vx_e    = {{2{vx1[9]}}, vx1} + {eng[10], eng};
    over    = !vx_e[11] && vx_e[10:0] > {1'b0, VXY_MAX};
    under   = vx_e[11] && vx_e < -{2'b00, VXY_MAX};
    cnt_inc = hit_cnt + 4'd1;
    up      = cnt_inc == HITS_PER_UP;
    mag_up  = up ? (vz_mag >= VZ_MAX ? VZ_MAX : vz_mag + 10'd1) : vz_mag;
    state_n     = state;
    serve_dir_n = serve_dir;
    vz_mag_n    = vz_mag;
    hit_cnt_n   = hit_cnt;
    hold_n      = hold;
    vel_x_n     = vel_x;
    vel_y_n     = vel_y;
    vel_z_n     = vel_z;
    player_n    = player_score;
    cpu_n       = cpu_score;
    hit_n       = 1'b0;
    miss_n      = 1'b0;
    case (state)
      SERVE: if (serve && !serve_q) begin
        state_n   = PLAY;
        vel_x_n   = V0_XY;
        vel_y_n   = V0_XY;
        vel_z_n   = serve_dir ? -V0_Z : V0_Z;
        vz_mag_n  = V0_Z;
        hit_cnt_n = '0;
      end
      PLAY: if ((near || far) && !on_pad) begin
        vel_x_n     = '0;
        vel_y_n     = '0;
        vel_z_n     = '0;
        cpu_n       = near && cpu_score != WIN_SCORE ? cpu_score + 4'd1 : cpu_score;
        player_n    = far && player_score != WIN_SCORE ? player_score + 4'd1 : player_score;
        serve_dir_n = near;
        miss_n      = 1'b1;
        hold_n      = MISS_HOLD - 8'd1;
        state_n     = MISS;
      end else begin
        vel_x_n = vx1;
        vel_y_n = vy1;
        if (near || far) begin
          // speed-up magnitude takes the reflected sign; english is added after any wall flip
          vel_z_n   = near ? mag_up : -mag_up;
          vz_mag_n  = mag_up;
          hit_cnt_n = up ? 4'd0 : cnt_inc;
          hit_n     = 1'b1;
          vel_x_n   = over ? VXY_MAX : under ? -VXY_MAX : vx_e[9:0];
        end
      end
      MISS: if (hold == '0)
        state_n = player_score == WIN_SCORE || cpu_score == WIN_SCORE ? OVER : SERVE;
      else
        hold_n = hold - 8'd1;
      OVER: state_n = OVER;
    endcase
  end
endmodule

// File: tb/tb_volley_ctrl.sv
// tb_volley_ctrl: directed-vector self-checking bench for volley_ctrl.
module tb_volley_ctrl;
  logic frame_clk = 1'b0, level_rst = 1'b1, serve = 1'b1;
  logic [9:0] pos_x, pos_y, pos_z, ply_x, ply_y, cpu_x, cpu_y;
  logic [9:0] vel_x, vel_y, vel_z;
  logic pause, hit_pulse, miss_pulse, game_over;
  logic [3:0] player_score, cpu_score;
  int n_cmp = 0, n_bad = 0;

  volley_ctrl dut (
    .frame_clk(frame_clk), .level_rst(level_rst), .serve(serve),
    .pos_x(pos_x), .pos_y(pos_y), .pos_z(pos_z),
    .ply_x(ply_x), .ply_y(ply_y), .cpu_x(cpu_x), .cpu_y(cpu_y),
    .vel_x(vel_x), .vel_y(vel_y), .vel_z(vel_z), .pause(pause),
    .player_score(player_score), .cpu_score(cpu_score),
    .hit_pulse(hit_pulse), .miss_pulse(miss_pulse), .game_over(game_over)
  );

  always #5 frame_clk = ~frame_clk;

  task automatic check(input string tag, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge frame_clk);
    #1;
  endtask

  task automatic set_pos(input int x, input int y, input int z);
    pos_x = 10'(x);
    pos_y = 10'(y);
    pos_z = 10'(z);
  endtask

  task automatic launch;
    serve = 1'b1;
    tick;
    serve = 1'b0;
  endtask

  // far-plane miss with the CPU paddle 100 px off, then the full hold
  task automatic far_miss_hold;
    set_pos(320, 240, 120);
    cpu_x = 10'd420;
    tick;
    set_pos(320, 240, 64);
    cpu_x = 10'd320;
    repeat (60) tick;
  endtask

  initial begin
    set_pos(320, 240, 64);
    ply_x = 10'd320; ply_y = 10'd240; cpu_x = 10'd320; cpu_y = 10'd240;
    repeat (2) tick;
    check("rst_pause", int'(pause), 1);
    check("rst_vz", int'($signed(vel_z)), 0);
    check("rst_pscore", int'(player_score), 0);
    check("rst_gover", int'(game_over), 0);
    check("rst_pulses", int'({hit_pulse, miss_pulse}), 0);
    level_rst = 1'b0;
    tick;
    check("held_serve_no_launch", int'(pause), 1);
    serve = 1'b0;
    tick;
    launch;
    check("launch_pause", int'(pause), 0);
    check("launch_vx", int'($signed(vel_x)), 1);
    check("launch_vy", int'($signed(vel_y)), 1);
    check("launch_vz", int'($signed(vel_z)), 2);
    set_pos(576, 240, 64);
    tick;
    check("xwall_flip", int'($signed(vel_x)), -1);
    set_pos(580, 432, 64);
    tick;
    check("xwall_no_reflip", int'($signed(vel_x)), -1);
    check("ywall_flip", int'($signed(vel_y)), -1);
    set_pos(64, 240, 64);
    tick;
    check("xwall_min_flip", int'($signed(vel_x)), 1);
    set_pos(320, 240, 120);
    tick;
    check("far_hit_vz", int'($signed(vel_z)), -2);
    check("far_hit_pulse", int'(hit_pulse), 1);
    set_pos(320, 240, 64);
    tick;
    check("hit_pulse_one_frame", int'(hit_pulse), 0);
    set_pos(340, 240, 8);
    tick;
    check("near_hit_vz", int'($signed(vel_z)), 2);
    check("near_hit_english", int'($signed(vel_x)), 2);
    check("near_hit_pulse", int'(hit_pulse), 1);
    set_pos(320, 240, 120);
    tick;
    set_pos(320, 240, 8);
    tick;
    check("fourth_hit_speedup", int'($signed(vel_z)), 3);
    for (int i = 5; i <= 24; i++) begin
      set_pos(320, 240, (i % 2) ? 120 : 8);
      tick;
      if (i == 16) check("hit16_vz", int'($signed(vel_z)), 6);
    end
    check("vz_cap", int'($signed(vel_z)), 6);
    set_pos(360, 240, 120);
    tick;
    check("english_pos", int'($signed(vel_x)), 4);
    check("far_hit_capped_vz", int'($signed(vel_z)), -6);
    set_pos(360, 240, 8);
    tick;
    check("english_clamp", int'($signed(vel_x)), 4);
    set_pos(280, 240, 120);
    tick;
    check("english_neg", int'($signed(vel_x)), 1);
    set_pos(320, 240, 8);
    tick;
    set_pos(320, 240, 120);
    cpu_x = 10'd420;
    tick;
    check("miss_pscore", int'(player_score), 1);
    check("miss_pulse", int'(miss_pulse), 1);
    check("miss_pause", int'(pause), 1);
    check("miss_vz", int'($signed(vel_z)), 0);
    set_pos(320, 240, 64);
    cpu_x = 10'd320;
    repeat (59) tick;
    check("miss_pulse_clear", int'(miss_pulse), 0);
    check("miss_hold_59", int'(pause), 1);
    serve = 1'b1;
    tick;
    check("miss_hold_60_no_serve", int'(pause), 1);
    serve = 1'b0;
    tick;
    launch;
    check("serve_after_miss_pause", int'(pause), 0);
    check("serve_dir_plus", int'($signed(vel_z)), 2);
    for (int r = 2; r <= 6; r++) begin
      far_miss_hold;
      launch;
      check("rally_relaunch", int'(pause), 0);
    end
    far_miss_hold;
    check("final_pscore", int'(player_score), 7);
    check("over_flag", int'(game_over), 1);
    tick;
    launch;
    check("over_ignores_serve", int'(pause), 1);
    check("over_vz", int'($signed(vel_z)), 0);
    check("over_held", int'(game_over), 1);
    level_rst = 1'b1;
    #1;
    check("async_rst_pscore", int'(player_score), 0);
    check("async_rst_gover", int'(game_over), 0);
    tick;
    level_rst = 1'b0;
    tick;
    launch;
    set_pos(320, 240, 120);
    tick;
    set_pos(320, 240, 8);
    ply_x = 10'd420;
    tick;
    check("near_miss_cscore", int'(cpu_score), 1);
    check("near_miss_pulse", int'(miss_pulse), 1);
    set_pos(320, 240, 64);
    ply_x = 10'd320;
    repeat (60) tick;
    launch;
    check("serve_dir_minus", int'($signed(vel_z)), -2);
    set_pos(320, 240, 8);
    ply_x = 10'd420;
    tick;
    check("near_miss_cscore2", int'(cpu_score), 2);
    set_pos(320, 240, 64);
    ply_x = 10'd320;
    repeat (10) tick;
    level_rst = 1'b1;
    #1;
    check("midmiss_rst_cscore", int'(cpu_score), 0);
    check("midmiss_rst_pause", int'(pause), 1);
    tick;
    level_rst = 1'b0;
    tick;
    launch;
    check("rst_serve_dir", int'($signed(vel_z)), 2);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
